// File: rtl/line_refill_pkg.sv
// Shared types for the cache line refill master: physical address, AXI ID,
// refill FSM states and the AXI3 read channel bundles.
package line_refill_pkg;

  typedef logic [31:0] phys_t;
  typedef logic [3:0]  axi_id_t;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_WAIT_ARREADY,
    RF_READ,
    RF_DONE
  } rf_state_t;

  typedef struct packed {
    phys_t       araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi3_rd_resp_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi3_rd_if.sv
// AXI3 read-channel bundle: request/response structs plus the ID signals.
interface axi3_rd_if;
  import line_refill_pkg::*;

  axi3_rd_req_t  axi3_rd_req;
  axi3_rd_resp_t axi3_rd_resp;
  axi_id_t       arid;
  axi_id_t       rid;

  modport master (output axi3_rd_req, output arid, input axi3_rd_resp, input rid);
  modport slave  (input axi3_rd_req, input arid, output axi3_rd_resp, output rid);

endinterface

// File: rtl/line_refill.sv
// Single-line AXI3 INCR burst reader for cache refill. One request in, one
// assembled line plus error summary out; beats are also forwarded as they land.
//
// state           | meaning
// RF_IDLE         | ready for a refill request
// RF_WAIT_ARREADY | AR issued, holding address until arready
// RF_READ         | collecting beats with matching rid
// RF_DONE         | one-cycle line_valid/line_err pulse
module line_refill
  import line_refill_pkg::*;
#(
  parameter int      LINE_WIDTH = 256,
  parameter axi_id_t ARID       = '0,
  localparam int     LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
  localparam int     BURST_LIMIT      = LINE_WIDTH / 32 - 1,
  localparam int     CNT_W            = LINE_BYTE_OFFSET - 2,
  localparam int     LABEL_W          = 32 - LINE_BYTE_OFFSET
) (
  input  logic                  clk,
  input  logic                  rst,
  axi3_rd_if.master             axi,
  input  phys_t                 i_req_addr,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  output logic [LINE_WIDTH-1:0] o_line_data,
  output logic                  o_line_valid,
  output logic                  o_line_err,
  output logic                  o_beat_valid,
  output logic [CNT_W-1:0]      o_beat_idx,
  output logic [31:0]           o_beat_data,
  output logic                  o_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LIMIT);

  rf_state_t                   r_state;
  logic                        r_arvalid;
  logic                        r_line_valid;
  logic                        r_req_ready;
  logic                        r_busy;
  logic [LABEL_W-1:0]          r_label;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_err;
  logic [BURST_LIMIT:0][31:0]  r_line;

  logic                        w_req_fire;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_beat_err;
  logic                        w_unused_offset;
  axi3_rd_req_t                w_req;

  // The byte offset within the line is irrelevant: the burst always starts at the line base.
  assign w_unused_offset = ^i_req_addr[LINE_BYTE_OFFSET-1:0];

  assign w_req_fire = (r_state == RF_IDLE) && i_req_valid;
  assign w_accept   = (r_state == RF_READ) && axi.axi3_rd_resp.rvalid && (axi.rid == ARID);
  assign w_last     = (r_cnt == CNT_LAST);
  // Bad response, or rlast disagreeing with our own beat count, marks the line bad.
  assign w_beat_err = (axi.axi3_rd_resp.rresp != AXI_RESP_OKAY) ||
                      (axi.axi3_rd_resp.rlast != w_last);

  // AR channel is fully static apart from the latched line label.
  always_comb begin
    w_req         = '0;
    w_req.araddr  = {r_label, {LINE_BYTE_OFFSET{1'b0}}};
    w_req.arlen   = 4'(BURST_LIMIT);
    w_req.arsize  = AXI_SIZE_4B;
    w_req.arburst = AXI_BURST_INCR;
    w_req.arvalid = r_arvalid;
    w_req.rready  = w_accept;
  end

  assign axi.axi3_rd_req = w_req;
  assign axi.arid        = ARID;

  assign o_req_ready  = r_req_ready;
  assign o_busy       = r_busy;
  assign o_line_valid = r_line_valid;
  assign o_line_err   = r_line_valid & r_err;
  assign o_line_data  = r_line;
  assign o_beat_valid = w_accept;
  assign o_beat_idx   = r_cnt;
  assign o_beat_data  = axi.axi3_rd_resp.rdata;

  // Refill sequencing with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RF_IDLE;
      r_arvalid    <= 1'b0;
      r_line_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        RF_IDLE: begin
          if (i_req_valid) begin
            r_state     <= RF_WAIT_ARREADY;
            r_arvalid   <= 1'b1;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        RF_WAIT_ARREADY: begin
          if (axi.axi3_rd_resp.arready) begin
            r_state   <= RF_READ;
            r_arvalid <= 1'b0;
          end
        end
        RF_READ: begin
          // Completion follows our own count; an early or missing rlast only flags an error.
          if (w_accept && w_last) begin
            r_state      <= RF_DONE;
            r_line_valid <= 1'b1;
          end
        end
        RF_DONE: begin
          r_state      <= RF_IDLE;
          r_line_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state      <= RF_IDLE;
          r_arvalid    <= 1'b0;
          r_line_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Label capture, beat counting, error accumulation and line assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_label <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_line  <= '0;
    end else if (w_req_fire) begin
      r_label <= i_req_addr[31:LINE_BYTE_OFFSET];
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_line[r_cnt] <= axi.axi3_rd_resp.rdata;
      r_err         <= r_err | w_beat_err;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_refill.sv
// Directed bench for line_refill: nominal burst, AR/R backpressure, error
// responses, rlast mismatch, foreign IDs, mid-burst reset and back-to-back refills.
module tb_line_refill;
  import line_refill_pkg::*;

  localparam int      LW = 256;
  localparam axi_id_t ID = 4'd2;

  logic          clk = 1'b0;
  logic          rst;
  phys_t         req_addr;
  logic          req_valid;
  logic          req_ready;
  logic [LW-1:0] line_data;
  logic          line_valid;
  logic          line_err;
  logic          beat_valid;
  logic [2:0]    beat_idx;
  logic [31:0]   beat_data;
  logic          busy;

  axi3_rd_if axi();

  line_refill #(.LINE_WIDTH(LW), .ARID(ID)) dut (
    .clk          (clk),
    .rst          (rst),
    .axi          (axi),
    .i_req_addr   (req_addr),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .o_line_data  (line_data),
    .o_line_valid (line_valid),
    .o_line_err   (line_err),
    .o_beat_valid (beat_valid),
    .o_beat_idx   (beat_idx),
    .o_beat_data  (beat_data),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int cyc      = 0;
  int t_acc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  task automatic do_request(input phys_t addr, input phys_t exp_araddr);
    req_addr  = addr;
    req_valid = 1'b1;
    #2;
    chk1("req_ready_before_accept", req_ready, 1'b1);
    t_acc = cyc;
    step();
    req_valid = 1'b0;
    #2;
    chk1("arvalid_rise", axi.axi3_rd_req.arvalid, 1'b1);
    chk1("busy_after_accept", busy, 1'b1);
    chk1("req_ready_after_accept", req_ready, 1'b0);
    chk32("araddr", axi.axi3_rd_req.araddr, exp_araddr);
    chk32("ar_fixed", {16'd0, axi.axi3_rd_req.arlen, axi.axi3_rd_req.arsize,
                       axi.axi3_rd_req.arburst, axi.arid, axi.axi3_rd_req.arlock,
                       axi.axi3_rd_req.arcache, axi.axi3_rd_req.arprot},
          {16'd0, 4'd7, 3'b010, 2'b01, ID, 2'b00, 4'h0, 3'h0});
    chk1("rready_in_wait", axi.axi3_rd_req.rready, 1'b0);
  endtask

  task automatic beat(input axi_id_t id, input logic [31:0] data, input logic [1:0] resp,
                      input logic last, input logic exp_acc, input logic [2:0] exp_idx);
    axi.rid                = id;
    axi.axi3_rd_resp.rdata = data;
    axi.axi3_rd_resp.rresp = resp;
    axi.axi3_rd_resp.rlast = last;
    axi.axi3_rd_resp.rvalid = 1'b1;
    #2;
    chk1("rready", axi.axi3_rd_req.rready, exp_acc);
    chk1("beat_valid", beat_valid, exp_acc);
    chk1("line_valid_during_burst", line_valid, 1'b0);
    if (exp_acc) begin
      chk32("beat_idx", 32'(beat_idx), 32'(exp_idx));
      chk32("beat_data", beat_data, data);
    end
    if (beat_valid) n_beats++;
    step();
    axi.axi3_rd_resp.rvalid = 1'b0;
    axi.axi3_rd_resp.rlast  = 1'b0;
    axi.axi3_rd_resp.rresp  = 2'b00;
  endtask

  task automatic gap();
    axi.axi3_rd_resp.rvalid = 1'b0;
    #2;
    chk1("beat_valid_gap", beat_valid, 1'b0);
    step();
  endtask

  task automatic run_line(input logic [31:0] base, input int err_beat, input int last_beat,
                          input bit gapped, input bit foreign);
    n_beats = 0;
    for (int k = 0; k < 8; k++) begin
      if (foreign) beat(axi_id_t'(ID + 1), 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 3'd0);
      beat(ID, base + 32'(k), (k == err_beat) ? 2'b10 : 2'b00, (k == last_beat), 1'b1, 3'(k));
      if (gapped && k != 7) gap();
    end
    chk32("beat_count", 32'(n_beats), 32'd8);
  endtask

  task automatic check_done(input logic [LW-1:0] exp_line, input logic exp_err);
    #2;
    chk1("line_valid", line_valid, 1'b1);
    chk1("line_err", line_err, exp_err);
    chkl("line_data", line_data, exp_line);
    chk1("busy_in_done", busy, 1'b1);
    chk1("req_ready_in_done", req_ready, 1'b0);
    step();
    #2;
    chk1("line_valid_single", line_valid, 1'b0);
    chk1("line_err_after", line_err, 1'b0);
    chk1("req_ready_return", req_ready, 1'b1);
    chk1("busy_clear", busy, 1'b0);
    chkl("line_data_hold", line_data, exp_line);
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_valid = 1'b0;
    axi.rid          = ID;
    axi.axi3_rd_resp = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state; rvalid while idle must be ignored.
    axi.axi3_rd_resp.rvalid = 1'b1;
    #2;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_arvalid", axi.axi3_rd_req.arvalid, 1'b0);
    chk1("rst_rready_idle", axi.axi3_rd_req.rready, 1'b0);
    chk1("rst_line_valid", line_valid, 1'b0);
    chk1("rst_beat_valid", beat_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_line_err", line_err, 1'b0);
    chkl("rst_line_data", line_data, '0);
    step();
    axi.axi3_rd_resp.rvalid = 1'b0;

    // 1: nominal, arready held high, rdata = beat index.
    axi.axi3_rd_resp.arready = 1'b1;
    do_request(32'h1fc0_0024, 32'h1fc0_0020);
    step();
    run_line(32'd0, -1, 7, 1'b0, 1'b0);
    chk32("latency", 32'(cyc - t_acc), 32'd10);
    check_done({32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0}, 1'b0);

    // 2: arready delayed 5 cycles, gapped rvalid.
    axi.axi3_rd_resp.arready = 1'b0;
    do_request(32'h0000_1234, 32'h0000_1220);
    for (int i = 0; i < 5; i++) begin
      axi.rid = ID;
      axi.axi3_rd_resp.rvalid = 1'b1;
      #2;
      chk1("wait_arvalid", axi.axi3_rd_req.arvalid, 1'b1);
      chk32("wait_araddr", axi.axi3_rd_req.araddr, 32'h0000_1220);
      chk32("wait_arlen", 32'(axi.axi3_rd_req.arlen), 32'd7);
      chk1("wait_rready", axi.axi3_rd_req.rready, 1'b0);
      step();
    end
    axi.axi3_rd_resp.rvalid  = 1'b0;
    axi.axi3_rd_resp.arready = 1'b1;
    #2;
    chk1("arvalid_at_arready", axi.axi3_rd_req.arvalid, 1'b1);
    step();
    axi.axi3_rd_resp.arready = 1'b0;
    #2;
    chk1("arvalid_drop", axi.axi3_rd_req.arvalid, 1'b0);
    step();
    run_line(32'h0000_00A0, -1, 7, 1'b1, 1'b0);
    check_done(mk_line(32'h0000_00A0), 1'b0);

    // 3: SLVERR on beat 3.
    axi.axi3_rd_resp.arready = 1'b1;
    do_request(32'h2000_0100, 32'h2000_0100);
    step();
    run_line(32'h0000_1000, 3, 7, 1'b0, 1'b0);
    check_done(mk_line(32'h0000_1000), 1'b1);

    // 4: rlast on beat 5, none on beat 7.
    do_request(32'h2000_013f, 32'h2000_0120);
    step();
    run_line(32'h0000_2000, -1, 5, 1'b0, 1'b0);
    check_done(mk_line(32'h0000_2000), 1'b1);

    // 5: foreign-ID beats interleaved.
    do_request(32'h3000_0040, 32'h3000_0040);
    step();
    run_line(32'h0000_3000, -1, 7, 1'b0, 1'b1);
    check_done(mk_line(32'h0000_3000), 1'b0);

    // 6a: reset at beat 4.
    do_request(32'h4000_0000, 32'h4000_0000);
    step();
    for (int k = 0; k < 4; k++) beat(ID, 32'h0000_4400 + 32'(k), 2'b00, 1'b0, 1'b1, 3'(k));
    rst = 1'b1;
    axi.rid = ID;
    axi.axi3_rd_resp.rvalid = 1'b1;
    step();
    rst = 1'b0;
    axi.axi3_rd_resp.rvalid = 1'b0;
    #2;
    chk1("midrst_req_ready", req_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_line_valid", line_valid, 1'b0);
    chk1("midrst_arvalid", axi.axi3_rd_req.arvalid, 1'b0);
    chkl("midrst_line_data", line_data, '0);
    step();
    #2;
    chk1("midrst_no_line_valid", line_valid, 1'b0);
    step();

    // 6b: back-to-back requests separated only by the line_valid cycle.
    do_request(32'h8000_0040, 32'h8000_0040);
    step();
    run_line(32'h0000_5000, -1, 7, 1'b0, 1'b0);
    check_done(mk_line(32'h0000_5000), 1'b0);
    do_request(32'h8000_0060, 32'h8000_0060);
    step();
    run_line(32'h0000_6000, -1, 7, 1'b0, 1'b0);
    check_done(mk_line(32'h0000_6000), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
